fpu_add_req_gen: RTL and testbench

// - Parametrised generator of FPU add/sub requests for scan-inject fault runs.
// - Drives one request at a time into the FPU add-pipe input port.
// - Each request carries opcode, rounding mode, IDs, two operands and the

---
 rtl/fpu_tb_pkg.sv | 55 +++++
 rtl/fpu_oprd_predecode.sv | 17 +
 rtl/fpu_add_req_gen.sv | 176 +++++++++++++++++
 tb/tb_fpu_add_req_gen.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_tb_pkg.sv
// Shared definitions for the FPU add-request generator: opcodes, special-value
// tables, LFSR polynomial and the burst FSM state type.
package fpu_tb_pkg;

  localparam logic [7:0] FADDS = 8'h41;
  localparam logic [7:0] FADDD = 8'h42;
  localparam logic [7:0] FSUBS = 8'h45;
  localparam logic [7:0] FSUBD = 8'h46;

  // Galois right-shift mask for x^64 + x^63 + x^61 + x^60 + 1
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_DONE
  } state_t;

  // {+0, -0, +1.0, +Inf, -Inf, qNaN, sNaN, min denorm}
  function automatic logic [63:0] special_d(input logic [2:0] i);
    case (i)
      3'd0:    return 64'h0000_0000_0000_0000;
      3'd1:    return 64'h8000_0000_0000_0000;
      3'd2:    return 64'h3FF0_0000_0000_0000;
      3'd3:    return 64'h7FF0_0000_0000_0000;
      3'd4:    return 64'hFFF0_0000_0000_0000;
      3'd5:    return 64'h7FF8_0000_0000_0000;
      3'd6:    return 64'h7FF4_0000_0000_0000;
      default: return 64'h0000_0000_0000_0001;
    endcase
  endfunction

  function automatic logic [31:0] special_s(input logic [2:0] i);
    case (i)
      3'd0:    return 32'h0000_0000;
      3'd1:    return 32'h8000_0000;
      3'd2:    return 32'h3F80_0000;
      3'd3:    return 32'h7F80_0000;
      3'd4:    return 32'hFF80_0000;
      3'd5:    return 32'h7FC0_0000;
      3'd6:    return 32'h7FA0_0000;
      default: return 32'h0000_0001;
    endcase
  endfunction

  function automatic logic [63:0] lfsr_step(input logic [63:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic is_single(input logic [7:0] op);
    return (op == FADDS) || (op == FSUBS);
  endfunction

endpackage

// File: rtl/fpu_oprd_predecode.sv
// Operand predecode flags for the add pipe; single-precision values live in
// [63:32]. The sign bit plays no part, so only [62:0] comes in.
module fpu_oprd_predecode (
  input  logic [62:0] oprd,
  input  logic        single,
  output logic        m50_0_neq_0,
  output logic        m53_32_neq_0,
  output logic        exp_neq_0,
  output logic        exp_neq_ff
);

  assign m50_0_neq_0  = |oprd[50:0];
  assign m53_32_neq_0 = |oprd[53:32];
  assign exp_neq_0    = single ? |oprd[62:55] : |oprd[62:52];
  assign exp_neq_ff   = single ? ~&oprd[62:55] : ~&oprd[62:52];

endmodule

// File: rtl/fpu_add_req_gen.sv
// Counted-burst generator of FPU add/sub requests with valid/ready handshake,
// LFSR random operands or a walk over the special-value table.
module fpu_add_req_gen
  import fpu_tb_pkg::*;
#(
  parameter int          N_REQ = 16,
  parameter logic [63:0] SEED1 = 64'hACE1_2468_1357_BDF0,
  parameter logic [63:0] SEED2 = 64'h0F1E_2D3C_4B5A_6978,
  parameter int          CNT_W = $clog2(N_REQ + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             add_rdy,
  output logic             add_req,
  output logic [7:0]       opcode,
  output logic [1:0]       round_mode,
  output logic [4:0]       req_id,
  output logic [1:0]       req_cc_id,
  output logic [63:0]      operand1,
  output logic [63:0]      operand2,
  output logic             oprd1_50_0_neq_0,
  output logic             oprd1_53_32_neq_0,
  output logic             oprd1_exp_neq_0,
  output logic             oprd1_exp_neq_ff,
  output logic             oprd2_50_0_neq_0,
  output logic             oprd2_53_32_neq_0,
  output logic             oprd2_exp_neq_0,
  output logic             oprd2_exp_neq_ff,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issued
);

  // Handshake: a request transfers at a rising edge where add_req && add_rdy;
  // while add_req is high and add_rdy low every request field holds still.

  state_t      state;
  logic        mode_q;
  logic [10:0] idx;
  logic [10:0] idx_inc;
  logic        last;
  logic        load;
  logic [63:0] lfsr1;
  logic [63:0] lfsr2;
  logic [63:0] l1_nxt;
  logic [63:0] l2_nxt;
  logic [6:0]  ld_idx;
  logic [7:0]  nxt_op;
  logic [1:0]  nxt_rm;
  logic        nxt_single;
  logic [63:0] nxt_o1;
  logic [63:0] nxt_o2;
  logic        cur_single;

  assign idx_inc = idx + 11'd1;
  assign last    = (idx_inc == 11'(N_REQ));
  assign load    = (state == ST_LOAD) || ((state == ST_ISSUE) && add_rdy && !last);
  assign issued  = idx[CNT_W-1:0];

  // Fields of the request that will be registered on the next load.
  always_comb begin
    ld_idx     = (state == ST_ISSUE) ? idx_inc[6:0] : idx[6:0];
    l1_nxt     = lfsr_step(lfsr1);
    l2_nxt     = lfsr_step(lfsr2);
    nxt_op     = FADDD;
    nxt_rm     = 2'd0;
    nxt_single = 1'b0;
    nxt_o1     = 64'd0;
    nxt_o2     = 64'd0;
    if (mode_q) begin
      case (ld_idx[1:0])
        2'd0:    nxt_op = FADDD;
        2'd1:    nxt_op = FSUBD;
        2'd2:    nxt_op = FADDS;
        default: nxt_op = FSUBS;
      endcase
      nxt_rm     = ld_idx[1:0];
      nxt_single = is_single(nxt_op);
      nxt_o1     = nxt_single ? {special_s(ld_idx[2:0]), 32'd0} : special_d(ld_idx[2:0]);
      nxt_o2     = nxt_single ? {special_s(ld_idx[5:3]), 32'd0} : special_d(ld_idx[5:3]);
    end else begin
      case (l1_nxt[1:0])
        2'd0:    nxt_op = FADDS;
        2'd1:    nxt_op = FADDD;
        2'd2:    nxt_op = FSUBS;
        default: nxt_op = FSUBD;
      endcase
      nxt_rm     = l2_nxt[1:0];
      nxt_single = is_single(nxt_op);
      nxt_o1     = nxt_single ? {l1_nxt[63:32], 32'd0} : l1_nxt;
      nxt_o2     = nxt_single ? {l2_nxt[63:32], 32'd0} : l2_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      mode_q     <= 1'b0;
      idx        <= 11'd0;
      lfsr1      <= SEED1;
      lfsr2      <= SEED2;
      add_req    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      opcode     <= 8'd0;
      round_mode <= 2'd0;
      req_id     <= 5'd0;
      req_cc_id  <= 2'd0;
      operand1   <= 64'd0;
      operand2   <= 64'd0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_LOAD;
            mode_q <= mode;
            lfsr1  <= SEED1;
            lfsr2  <= SEED2;
            idx    <= 11'd0;
            busy   <= 1'b1;
          end
        end
        ST_LOAD: begin
          add_req <= 1'b1;
          state   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (add_rdy) begin
            idx <= idx_inc;
            if (last) begin
              add_req <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (load) begin
        lfsr1      <= l1_nxt;
        lfsr2      <= l2_nxt;
        opcode     <= nxt_op;
        round_mode <= nxt_rm;
        req_id     <= ld_idx[4:0];
        req_cc_id  <= ld_idx[6:5];
        operand1   <= nxt_o1;
        operand2   <= nxt_o2;
      end
    end
  end

  assign cur_single = is_single(opcode);

  fpu_oprd_predecode u_pd1 (
    .oprd         (operand1[62:0]),
    .single       (cur_single),
    .m50_0_neq_0  (oprd1_50_0_neq_0),
    .m53_32_neq_0 (oprd1_53_32_neq_0),
    .exp_neq_0    (oprd1_exp_neq_0),
    .exp_neq_ff   (oprd1_exp_neq_ff)
  );

  fpu_oprd_predecode u_pd2 (
    .oprd         (operand2[62:0]),
    .single       (cur_single),
    .m50_0_neq_0  (oprd2_50_0_neq_0),
    .m53_32_neq_0 (oprd2_53_32_neq_0),
    .exp_neq_0    (oprd2_exp_neq_0),
    .exp_neq_ff   (oprd2_exp_neq_ff)
  );

endmodule

// File: tb/tb_fpu_add_req_gen.sv
// Directed bench for fpu_add_req_gen: a 4-request and a 40-request instance
// share clock and reset.
module tb_fpu_add_req_gen;

  localparam int W = 138;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // instance a: N_REQ=4
  logic a_start = 1'b0, a_mode = 1'b0, a_rdy = 1'b0;
  logic a_add_req, a_busy, a_done;
  logic [7:0] a_opcode;
  logic [1:0] a_round_mode, a_cc;
  logic [4:0] a_id;
  logic [63:0] a_operand1, a_operand2;
  logic a_f1_50, a_f1_53, a_f1_e0, a_f1_eff, a_f2_50, a_f2_53, a_f2_e0, a_f2_eff;
  logic [2:0] a_issued;

  // instance b: N_REQ=40
  logic b_start = 1'b0, b_mode = 1'b0, b_rdy = 1'b0;
  logic b_add_req, b_busy, b_done;
  logic [7:0] b_opcode;
  logic [1:0] b_round_mode, b_cc;
  logic [4:0] b_id;
  logic [63:0] b_operand1, b_operand2;
  logic b_f1_50, b_f1_53, b_f1_e0, b_f1_eff, b_f2_50, b_f2_53, b_f2_e0, b_f2_eff;
  logic [5:0] b_issued;

  fpu_add_req_gen #(.N_REQ(4)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .mode(a_mode), .add_rdy(a_rdy),
    .add_req(a_add_req), .opcode(a_opcode), .round_mode(a_round_mode),
    .req_id(a_id), .req_cc_id(a_cc), .operand1(a_operand1), .operand2(a_operand2),
    .oprd1_50_0_neq_0(a_f1_50), .oprd1_53_32_neq_0(a_f1_53),
    .oprd1_exp_neq_0(a_f1_e0), .oprd1_exp_neq_ff(a_f1_eff),
    .oprd2_50_0_neq_0(a_f2_50), .oprd2_53_32_neq_0(a_f2_53),
    .oprd2_exp_neq_0(a_f2_e0), .oprd2_exp_neq_ff(a_f2_eff),
    .busy(a_busy), .done(a_done), .issued(a_issued)
  );

  fpu_add_req_gen #(.N_REQ(40)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .mode(b_mode), .add_rdy(b_rdy),
    .add_req(b_add_req), .opcode(b_opcode), .round_mode(b_round_mode),
    .req_id(b_id), .req_cc_id(b_cc), .operand1(b_operand1), .operand2(b_operand2),
    .oprd1_50_0_neq_0(b_f1_50), .oprd1_53_32_neq_0(b_f1_53),
    .oprd1_exp_neq_0(b_f1_e0), .oprd1_exp_neq_ff(b_f1_eff),
    .oprd2_50_0_neq_0(b_f2_50), .oprd2_53_32_neq_0(b_f2_53),
    .oprd2_exp_neq_0(b_f2_e0), .oprd2_exp_neq_ff(b_f2_eff),
    .busy(b_busy), .done(b_done), .issued(b_issued)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  op;
    logic [1:0]  rm;
    logic [4:0]  id;
    logic [63:0] o1;
    logic [63:0] o2;
    logic [3:0]  f1;
    logic [3:0]  f2;
  } vec_t;

  vec_t        vecs[4];
  logic [63:0] sp_d[8];
  logic [31:0] sp_s[8];
  logic [7:0]  op_sp[4];
  logic [7:0]  op_rnd[4];
  logic        rdy_pat[64];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_vec(input int i, input string tag);
    chk({tag, "_op"}, a_opcode, vecs[i].op);
    chk({tag, "_rm"}, a_round_mode, vecs[i].rm);
    chk({tag, "_id"}, a_id, vecs[i].id);
    chk({tag, "_op1"}, a_operand1, vecs[i].o1);
    chk({tag, "_op2"}, a_operand2, vecs[i].o2);
    chk({tag, "_f1"}, {a_f1_50, a_f1_53, a_f1_e0, a_f1_eff}, vecs[i].f1);
    chk({tag, "_f2"}, {a_f2_50, a_f2_53, a_f2_e0, a_f2_eff}, vecs[i].f2);
  endtask

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    logic [63:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 64'hD800_0000_0000_0000;
    return r;
  endfunction

  // Random burst on instance a; burst 1 checks the LFSR model, burst 2 replays burst 1.
  task automatic run_random(input int burst_no);
    int n;
    bit seen_done;
    logic [W-1:0] rec, e;
    n = 0;
    seen_done = 1'b0;
    a_mode = 1'b0;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 64 && !seen_done; c++) begin
      a_rdy = rdy_pat[c];
      if (a_add_req && a_rdy) begin
        rec = {a_round_mode, a_opcode, a_operand1, a_operand2};
        e = '0;
        if (burst_no == 1) begin
          if (exp_q.size() > 0) e = exp_q.pop_front();
          got_q.push_back(rec);
        end else if (got_q.size() > 0) begin
          e = got_q.pop_front();
        end
        chk($sformatf("rnd%0d_req%0d", burst_no, n), rec, e);
        if (a_opcode == 8'h41 || a_opcode == 8'h45)
          chk($sformatf("rnd%0d_single_low%0d", burst_no, n), {a_operand1[31:0], a_operand2[31:0]}, '0);
        n++;
      end
      if (a_done) seen_done = 1'b1;
      tick();
    end
    chk($sformatf("rnd%0d_count", burst_no), n, 4);
    chk($sformatf("rnd%0d_done_seen", burst_no), seen_done, 1);
    chk($sformatf("rnd%0d_issued", burst_no), a_issued, 4);
  endtask

  initial begin
    logic [63:0] s1, s2, o1, o2, eo1, eo2;
    logic [7:0]  op;
    bit          dbl;
    int          done_cnt;

    sp_d = '{64'h0, 64'h8000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h7FF0_0000_0000_0000,
             64'hFFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h7FF4_0000_0000_0000, 64'h1};
    sp_s = '{32'h0, 32'h8000_0000, 32'h3F80_0000, 32'h7F80_0000,
             32'hFF80_0000, 32'h7FC0_0000, 32'h7FA0_0000, 32'h1};
    op_sp  = '{8'h42, 8'h46, 8'h41, 8'h45};
    op_rnd = '{8'h41, 8'h42, 8'h45, 8'h46};
    vecs[0] = '{op: 8'h42, rm: 2'd0, id: 5'd0, o1: 64'h0,                   o2: 64'h0, f1: 4'b0001, f2: 4'b0001};
    vecs[1] = '{op: 8'h46, rm: 2'd1, id: 5'd1, o1: 64'h8000_0000_0000_0000, o2: 64'h0, f1: 4'b0001, f2: 4'b0001};
    vecs[2] = '{op: 8'h41, rm: 2'd2, id: 5'd2, o1: 64'h3F80_0000_0000_0000, o2: 64'h0, f1: 4'b0011, f2: 4'b0001};
    vecs[3] = '{op: 8'h45, rm: 2'd3, id: 5'd3, o1: 64'h7F80_0000_0000_0000, o2: 64'h0, f1: 4'b0010, f2: 4'b0001};
    for (int c = 0; c < 64; c++) rdy_pat[c] = (c >= 40) ? 1'b1 : 1'($urandom_range(0, 1));

    // reset state
    repeat (3) tick();
    chk("rst_add_req", a_add_req, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_issued", a_issued, 0);
    chk("rst_operand1", a_operand1, 0);
    chk("rst_exp_neq_ff", a_f1_eff, 1);
    rst = 1'b1;
    tick();

    // special-mode burst, full throughput
    a_mode = 1'b1;
    a_rdy = 1'b1;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    chk("load_add_req", a_add_req, 0);
    chk("load_busy", a_busy, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("sp_req%0d", i), a_add_req, 1);
      chk($sformatf("sp_issued%0d", i), a_issued, i);
      check_a_vec(i, $sformatf("sp%0d", i));
      tick();
    end
    chk("sp_end_add_req", a_add_req, 0);
    chk("sp_done", a_done, 1);
    chk("sp_issued_end", a_issued, 4);
    chk("sp_busy_end", a_busy, 0);
    tick();
    chk("sp_done_pulse", a_done, 0);
    chk("sp_issued_hold", a_issued, 4);

    // stall for 5 cycles on the first request
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    a_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall%0d_req", k), a_add_req, 1);
      chk($sformatf("stall%0d_issued", k), a_issued, 0);
      check_a_vec(0, $sformatf("stall%0d", k));
    end
    a_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_a_vec(i, $sformatf("resume%0d", i));
      tick();
    end
    chk("stall_done", a_done, 1);
    chk("stall_issued", a_issued, 4);
    tick();

    // reset in the middle of a burst
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    tick();
    chk("pre_abort_req", a_add_req, 1);
    rst = 1'b0;
    #1;
    chk("abort_add_req", a_add_req, 0);
    chk("abort_busy", a_busy, 0);
    chk("abort_issued", a_issued, 0);
    chk("abort_operand1", a_operand1, 0);
    chk("abort_exp_neq_ff", a_f1_eff, 1);
    tick();
    rst = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      if (a_done) done_cnt++;
      tick();
    end
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle", a_add_req, 0);

    // 40-request special burst: ID wrap, predecode corners, ignored starts
    b_mode = 1'b1;
    b_rdy = 1'b1;
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    tick();
    for (int i = 0; i < 40; i++) begin
      op  = op_sp[i % 4];
      dbl = (op == 8'h42) || (op == 8'h46);
      eo1 = dbl ? sp_d[i % 8] : {sp_s[i % 8], 32'h0};
      eo2 = dbl ? sp_d[(i / 8) % 8] : {sp_s[(i / 8) % 8], 32'h0};
      chk($sformatf("b%0d_req", i), b_add_req, 1);
      chk($sformatf("b%0d_issued", i), b_issued, i);
      chk($sformatf("b%0d_op", i), b_opcode, op);
      chk($sformatf("b%0d_rm", i), b_round_mode, i % 4);
      chk($sformatf("b%0d_id", i), {b_cc, b_id}, i % 128);
      chk($sformatf("b%0d_op1", i), b_operand1, eo1);
      chk($sformatf("b%0d_op2", i), b_operand2, eo2);
      if (i == 7) begin
        chk("denorm_exp_neq_0", b_f1_e0, 0);
        chk("denorm_50_0_neq_0", b_f1_50, 1);
      end
      if (i == 24) begin
        chk("inf_exp_neq_0", b_f2_e0, 1);
        chk("inf_exp_neq_ff", b_f2_eff, 0);
        chk("inf_50_0_neq_0", b_f2_50, 0);
      end
      if (i == 32) chk("id_wrap", {b_cc, b_id}, {2'd1, 5'd0});
      b_start = (i == 10 || i == 20);
      tick();
    end
    b_start = 1'b0;
    chk("b_done", b_done, 1);
    chk("b_issued_end", b_issued, 40);
    tick();
    tick();
    chk("b_no_restart", b_add_req, 0);
    chk("b_idle_busy", b_busy, 0);

    // random mode: model for burst 1, burst 2 must repeat it
    s1 = 64'hACE1_2468_1357_BDF0;
    s2 = 64'h0F1E_2D3C_4B5A_6978;
    for (int k = 0; k < 4; k++) begin
      s1 = lfsr_next(s1);
      s2 = lfsr_next(s2);
      op = op_rnd[s1[1:0]];
      dbl = (op == 8'h42) || (op == 8'h46);
      o1 = dbl ? s1 : {s1[63:32], 32'h0};
      o2 = dbl ? s2 : {s2[63:32], 32'h0};
      exp_q.push_back({s2[1:0], op, o1, o2});
    end
    run_random(1);
    tick();
    run_random(2);
    chk("rnd_queues_empty", exp_q.size() + got_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
